// File: rtl/debug_defs.sv
// Shared definitions for the CPU debug port and its arbiter.
package debug_defs;

  // Debug port register map
  localparam logic [1:0] DBG_ADDR_CMD    = 2'b00;
  localparam logic [1:0] DBG_ADDR_ADDR   = 2'b01;
  localparam logic [1:0] DBG_ADDR_DATA   = 2'b10;
  localparam logic [1:0] DBG_ADDR_RESULT = 2'b11;

  // Arbiter states, one-hot encoded
  typedef enum logic [3:0] {
    StIdle = 4'b0001,
    StBusy = 4'b0010,
    StDone = 4'b0100,
    StHold = 4'b1000
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin select: first requester at or after ptr wins.
module rr_pick #(
  parameter int unsigned N = 2,
  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant
);

  // Scan the requesters starting at the pointer, wrapping at N
  always_comb begin : pick_loop
    logic          found;
    logic [PW-1:0] idx;
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = PW'((32'(ptr) + k) % N);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/debug_port_arbiter.sv
// Round-robin arbiter sharing the CPU debug port between several requesters,
// with an optional per-owner lock that is dropped after an idle timeout.
module debug_port_arbiter
  import debug_defs::*;
#(
  parameter int unsigned NUM_MASTERS  = 2,
  parameter int unsigned LOCK_TIMEOUT = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_MASTERS-1:0]    m_req,
  input  logic [NUM_MASTERS-1:0]    m_lock,
  input  logic [NUM_MASTERS-1:0]    m_wr_en,
  input  logic [2*NUM_MASTERS-1:0]  m_addr,
  input  logic [32*NUM_MASTERS-1:0] m_wdata,
  output logic [NUM_MASTERS-1:0]    m_ack,
  output logic [31:0]               m_rdata,
  output logic [NUM_MASTERS-1:0]    m_grant,
  output logic                      lock_expired,
  output logic [1:0]                dbg_addr,
  output logic [31:0]               dbg_wdata,
  output logic                      dbg_wr_en,
  output logic                      dbg_req,
  input  logic                      dbg_ack,
  input  logic [31:0]               dbg_rdata
);

  localparam int unsigned PW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int unsigned CW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
  localparam logic [CW-1:0] CntMax = CW'(LOCK_TIMEOUT - 1);

  arb_state_e             state_q;
  logic [NUM_MASTERS-1:0] grant_q;
  logic [NUM_MASTERS-1:0] ack_q;
  logic [PW-1:0]          ptr_q;
  logic [PW-1:0]          owner_q;
  logic [1:0]             addr_q;
  logic [31:0]            wdata_q;
  logic [31:0]            rdata_q;
  logic                   wr_q;
  logic                   expired_q;
  logic                   hold_ack_q;
  logic [CW-1:0]          cnt_q;

  logic [NUM_MASTERS-1:0] pick;
  logic [PW-1:0]          pick_idx;
  logic [PW-1:0]          src;
  logic [PW-1:0]          ptr_adv;
  logic [1:0]             sel_addr;
  logic [31:0]            sel_wdata;
  logic                   sel_wr;

  rr_pick #(
    .N (NUM_MASTERS)
  ) u_rr_pick (
    .req   (m_req),
    .ptr   (ptr_q),
    .grant (pick)
  );

  // Encode the one-hot winner into an index
  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (pick[i]) pick_idx = PW'(i);
    end
  end

  // Select the transaction fields of the winner (IDLE) or of the lock owner (HOLD)
  always_comb begin
    src       = (state_q == StIdle) ? pick_idx : owner_q;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_wr    = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (PW'(i) == src) begin
        sel_addr  = m_addr[2*i +: 2];
        sel_wdata = m_wdata[32*i +: 32];
        sel_wr    = m_wr_en[i];
      end
    end
  end

  // Pointer position just past the current owner, wrapping at NUM_MASTERS
  always_comb begin
    ptr_adv = (owner_q == PW'(NUM_MASTERS - 1)) ? '0 : owner_q + PW'(1);
  end

  // Arbitration FSM; all master-facing outputs are registered here
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      grant_q    <= '0;
      ack_q      <= '0;
      ptr_q      <= '0;
      owner_q    <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      wr_q       <= 1'b0;
      expired_q  <= 1'b0;
      hold_ack_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      ack_q     <= '0;
      expired_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (|m_req) begin
            owner_q <= pick_idx;
            grant_q <= pick;
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
            wr_q    <= sel_wr;
            cnt_q   <= '0;
            state_q <= StBusy;
          end
        end
        StBusy: begin
          if (dbg_ack) begin
            rdata_q    <= dbg_rdata;
            ack_q      <= grant_q;
            hold_ack_q <= m_lock[owner_q];
            state_q    <= m_lock[owner_q] ? StHold : StDone;
          end
        end
        StDone: begin
          grant_q <= '0;
          ptr_q   <= ptr_adv;
          state_q <= StIdle;
        end
        StHold: begin
          hold_ack_q <= 1'b0;
          // The ack cycle is skipped for decisions: the owner's m_req is still
          // the one just answered.
          if (!hold_ack_q && m_req[owner_q]) begin
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
            wr_q    <= sel_wr;
            cnt_q   <= '0;
            state_q <= StBusy;
          end else if (!hold_ack_q && !m_lock[owner_q]) begin
            grant_q <= '0;
            ptr_q   <= ptr_adv;
            state_q <= StIdle;
          end else if (cnt_q == CntMax) begin
            grant_q   <= '0;
            ptr_q     <= ptr_adv;
            expired_q <= 1'b1;
            state_q   <= StIdle;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // dbg_req falls in the ack cycle itself so the port never sees a second request
  assign dbg_req      = (state_q == StBusy) && !dbg_ack;
  assign dbg_addr     = addr_q;
  assign dbg_wdata    = wdata_q;
  assign dbg_wr_en    = wr_q;
  assign m_grant      = grant_q;
  assign m_ack        = ack_q;
  assign m_rdata      = rdata_q;
  assign lock_expired = expired_q;

  a_grant_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(m_grant));
  a_ack_owner:    assert property (@(posedge clk) disable iff (rst) (m_ack & ~m_grant) == '0);
  a_req_busy:     assert property (@(posedge clk) disable iff (rst) dbg_req |-> state_q == StBusy);

endmodule
